// File: rtl/keccak_pkg.sv
// Shared constants and state encoding for the SHA-3 padding blocks.
package keccak_pkg;

    localparam int WORD_W = 32;

    localparam logic [7:0] PAD_FIRST = 8'h01;
    localparam logic [7:0] PAD_LAST  = 8'h80;
    localparam logic [7:0] PAD_BOTH  = 8'h81;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        EMIT
    } unpad_state_t;

endpackage

// File: rtl/unpad_locate.sv
// Finds the message length inside a padded final block.
// Combinational; byte 0 is the MSB byte of blk.
module unpad_locate
    import keccak_pkg::*;
#(
    parameter int RATE_WORDS = 18,
    localparam int NB = 4 * RATE_WORDS,
    localparam int LEN_W = $clog2(NB)
) (
    input  logic [WORD_W*RATE_WORDS-1:0] blk,
    output logic                         valid,
    output logic [LEN_W-1:0]             len,
    output logic [1:0]                   rem
);

    logic             found;
    logic [LEN_W-1:0] jpos;
    logic [7:0]       jbyte;
    logic [7:0]       lastb;

    always_comb begin
        found = 1'b0;
        jpos  = '0;
        jbyte = '0;
        // Ascending scan, so the last hit is the highest nonzero byte.
        for (int j = 0; j < NB - 1; j++) begin
            if (blk[8*(NB-1-j) +: 8] != 8'h00) begin
                found = 1'b1;
                jpos  = LEN_W'(j);
                jbyte = blk[8*(NB-1-j) +: 8];
            end
        end
        lastb = blk[7:0];
        valid = 1'b0;
        len   = '0;
        if (lastb == PAD_BOTH) begin
            valid = 1'b1;
            len   = LEN_W'(NB - 1);
        end else if (lastb == PAD_LAST && found && jbyte == PAD_FIRST) begin
            valid = 1'b1;
            len   = jpos;
        end
    end

    assign rem = len[1:0];

endmodule

// File: rtl/keccak_unpadder.sv
// Strips SHA-3 padding from rate blocks and streams the message
// as 32-bit words in the padder's input convention.
module keccak_unpadder
    import keccak_pkg::*;
#(
    parameter int RATE_WORDS = 18
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [WORD_W*RATE_WORDS-1:0] in,
    input  logic                         in_ready,
    input  logic                         in_last,
    output logic                         in_ack,
    output logic [WORD_W-1:0]            out,
    output logic                         out_ready,
    output logic                         is_last,
    output logic [1:0]                   byte_num,
    input  logic                         sink_full,
    output logic                         pad_error
);

    localparam int BW    = WORD_W * RATE_WORDS;
    localparam int LEN_W = $clog2(4 * RATE_WORDS);
    localparam int CNT_W = $clog2(RATE_WORDS + 1);

    unpad_state_t     state, state_n;
    logic [BW-1:0]    blk;
    logic [CNT_W-1:0] cnt;
    logic             last_blk;
    logic [1:0]       rem_q;
    logic             pad_err_q;

    logic             loc_valid;
    logic [LEN_W-1:0] loc_len;
    logic [1:0]       loc_rem;

    logic             fire;
    logic             final_word;
    logic [WORD_W-1:0] word;
    logic [WORD_W-1:0] mask;

    unpad_locate #(
        .RATE_WORDS(RATE_WORDS)
    ) u_locate (
        .blk   (blk),
        .valid (loc_valid),
        .len   (loc_len),
        .rem   (loc_rem)
    );

    assign fire       = (state == EMIT) && !sink_full;
    assign final_word = last_blk && (cnt == CNT_W'(1));

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (in_ready) state_n = in_last ? CHECK : EMIT;
            CHECK:   state_n = loc_valid ? EMIT : IDLE;
            EMIT:    if (fire && cnt == CNT_W'(1)) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            blk       <= '0;
            cnt       <= '0;
            last_blk  <= 1'b0;
            rem_q     <= 2'd0;
            pad_err_q <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (in_ready) begin
                        blk      <= in;
                        cnt      <= CNT_W'(RATE_WORDS);
                        last_blk <= 1'b0;
                        rem_q    <= 2'd0;
                    end
                end
                CHECK: begin
                    if (loc_valid) begin
                        cnt      <= CNT_W'(loc_len >> 2) + CNT_W'(1);
                        rem_q    <= loc_rem;
                        last_blk <= 1'b1;
                    end else begin
                        pad_err_q <= 1'b1;
                    end
                end
                EMIT: begin
                    if (fire) begin
                        blk <= blk << WORD_W;
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Keep only the leading rem bytes of the final word.
    assign mask = ~(32'hFFFF_FFFF >> (8 * rem_q));
    assign word = blk[BW-1 -: WORD_W];

    assign in_ack    = (state == IDLE) && in_ready && !reset;
    assign out_ready = (state == EMIT);
    assign is_last   = out_ready && final_word;
    assign byte_num  = is_last ? rem_q : 2'd0;
    assign out       = !out_ready ? '0 : (is_last ? (word & mask) : word);
    assign pad_error = pad_err_q;

endmodule

// File: tb/tb_keccak_unpadder.sv
// Directed bench for keccak_unpadder: word streams, stalls,
// padding errors and mid-block reset.
module tb_keccak_unpadder;

    localparam int BW = 576;

    logic          clk = 1'b0;
    logic          reset;
    logic [BW-1:0] in;
    logic          in_ready;
    logic          in_last;
    logic          in_ack;
    logic [31:0]   out;
    logic          out_ready;
    logic          is_last;
    logic [1:0]    byte_num;
    logic          sink_full;
    logic          pad_error;

    keccak_unpadder #(.RATE_WORDS(18)) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .in_ack    (in_ack),
        .out       (out),
        .out_ready (out_ready),
        .is_last   (is_last),
        .byte_num  (byte_num),
        .sink_full (sink_full),
        .pad_error (pad_error)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_ack  = 0;
    int n_ordy = 0;

    logic [34:0] got_q[$];
    logic [34:0] exp_q[$];

    always @(negedge clk) begin
        if (!reset) begin
            if (out_ready && !sink_full)
                got_q.push_back({is_last, byte_num, out});
            if (in_ack) n_ack++;
            if (out_ready) n_ordy++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic push_alt(input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back({1'b0, 2'd0,
                             (i % 2 == 0) ? 32'h12345678 : 32'h90ABCDEF});
    endtask

    task automatic send(input logic [BW-1:0] b, input logic last);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        in = b;
        in_last = last;
        in_ready = 1'b1;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (in_ack) got = 1'b1;
        end
        if (!got) check("ack_timeout", 0, 1);
        @(posedge clk); #1;
        in_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cmp_q(input string tag);
        int n;
        check({tag, "_nwords"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    logic [31:0] held;
    int          a0;
    int          o0;

    initial begin
        reset = 1'b1;
        in = '0;
        in_ready = 1'b0;
        in_last = 1'b0;
        sink_full = 1'b0;
        idle(2);
        reset = 1'b0;
        @(negedge clk);
        check("rst_outs", {in_ack, out_ready, is_last, byte_num, pad_error, out},
              '0);

        // Empty message
        a0 = n_ack;
        send({8'h01, 560'h0, 8'h80}, 1'b1);
        idle(10);
        exp_q.push_back({1'b1, 2'd0, 32'h0});
        cmp_q("empty");
        check("empty_acks", n_ack - a0, 1);
        check("empty_perr", pad_error, 0);

        // PAD_BOTH, rem = 3
        send({{8{64'h1234567890ABCDEF}}, 64'h1234567890ABCD81}, 1'b1);
        idle(30);
        push_alt(17);
        exp_q.push_back({1'b1, 2'd3, 32'h90ABCD00});
        cmp_q("both");

        // Pad in its own word, rem = 0
        send({{8{64'h1234567890ABCDEF}}, 64'h0100000000000080}, 1'b1);
        idle(30);
        push_alt(16);
        exp_q.push_back({1'b1, 2'd0, 32'h0});
        cmp_q("rem0");

        // Two-block message with a stall in block 1
        send({9{64'h1234567890ABCDEF}}, 1'b0);
        idle(4);
        sink_full = 1'b1;
        held = out;
        repeat (3) begin
            @(negedge clk);
            check("stall_hold", {out_ready, out}, {1'b1, held});
        end
        @(posedge clk); #1;
        sink_full = 1'b0;
        send({{8{64'h1234567890ABCDEF}}, 64'h1234567890AB0180}, 1'b1);
        idle(30);
        push_alt(18);
        push_alt(17);
        exp_q.push_back({1'b1, 2'd2, 32'h90AB0000});
        cmp_q("two_blk");
        check("two_perr", pad_error, 0);

        // Malformed padding, then a clean empty block
        send({8'h02, 560'h0, 8'h80}, 1'b1);
        idle(10);
        check("bad_perr", pad_error, 1);
        cmp_q("bad");
        send({8'h01, 560'h0, 8'h80}, 1'b1);
        idle(10);
        exp_q.push_back({1'b1, 2'd0, 32'h0});
        cmp_q("after_bad");
        check("sticky_perr", pad_error, 1);

        // Reset at word 5 of a full block
        in = {9{64'h1234567890ABCDEF}};
        in_last = 1'b0;
        in_ready = 1'b1;
        for (int k = 0; k < 100 && got_q.size() < 5; k++)
            @(posedge clk);
        #1;
        in_ready = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_outs",
              {in_ack, out_ready, is_last, byte_num, pad_error, out}, '0);
        o0 = n_ordy;
        idle(10);
        check("midrst_quiet", n_ordy - o0, 0);
        got_q.delete();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/keccak_unpadder.md
Name: keccak_unpadder

Overview:
- Inverse of the SHA-3 padder: accepts padded rate blocks of 576 bits with a valid/ack handshake and recovers the original message as a 32-bit word stream.
- Output stream uses the padder's input convention (`out_ready`, `is_last`, `byte_num`, with `sink_full` backpressure), so the unpadder's output can feed a padder directly.
- Used for loopback verification of the padder and for the decoder path that strips padding from stored blocks.

Parameters:
- `RATE_WORDS`, default 18: number of 32-bit words per block. Block width is 32*`RATE_WORDS` (576 by default). Legal values: 18, 26, 34, 36.

Ports:
- `clk`  input  1  clock; all logic is on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `in`  input  32*`RATE_WORDS`  padded block; the first message byte is in bits [MSB:MSB-7].
- `in_ready`  input  1  `in` holds a valid block.
- `in_last`  input  1  the block is the final, padded block of the message; qualified by `in_ready`.
- `in_ack`  output  1  one-cycle pulse; the block on `in` has been taken.
- `out`  output  32  message word; the earliest byte is in [31:24].
- `out_ready`  output  1  `out`, `is_last` and `byte_num` are valid.
- `is_last`  output  1  the current word is the final word of the message.
- `byte_num`  output  2  number of valid bytes in the final word (0..3); 0 when `is_last` is 0.
- `sink_full`  input  1  downstream stall. A word transfers in each cycle where `out_ready` is 1 and `sink_full` is 0.
- `pad_error`  output  1  sticky: malformed padding was detected.

Behaviour:
- Reset value of every output is 0. Reset also clears the block buffer, word counter, state and `pad_error`, and returns to IDLE. Reset mid-operation drops the current block; no further words are emitted and no ack is issued.
- States: IDLE, CHECK, EMIT.
- IDLE:
  - If `in_ready`=1, latch `in` and `in_last`, and pulse `in_ack` in the same cycle.
  - Next state is CHECK if `in_last`=1, otherwise EMIT with count=`RATE_WORDS` and `last_blk`=0.
  - `in_ack` is never asserted outside IDLE.
- CHECK (exactly 1 cycle; scans bytes B0..B(N-1), where N=4*`RATE_WORDS` and B0 is the MSB byte):
  - If B(N-1)=8'h81, then L=N-1.
  - Else if B(N-1)=8'h80, find the highest j<N-1 with Bj≠0. This requires Bj=8'h01, and then L=j.
  - Any other case is an error: no j exists, Bj≠8'h01, or the final byte is not 8'h80/8'h81. On error, set `pad_error`=1, emit nothing, and go to IDLE.
  - If valid: count=L/4+1, rem=L%4, `last_blk`=1, go to EMIT.
- EMIT:
  - `out_ready`=1 and `out` = buffer[top 32 bits].
  - On transfer: shift the buffer left 32 and decrement count. When count reaches 0, go to IDLE; `out_ready` drops the next cycle.
  - `is_last`=1 and `byte_num`=rem only on the word where `last_blk`=1 and count=1.
  - In that final word, bytes at positions ≥rem are forced to 0.
  - While `sink_full`=1, the word, `is_last` and `byte_num` are held stable.
- Word counts:
  - Non-final block: exactly `RATE_WORDS` words, none with `is_last`.
  - Final block: L/4 full words plus one `is_last` word, which is emitted even when rem=0. An empty message gives a single word with `is_last`=1, `byte_num`=0, `out`=0.
- Latency: `in_ack` in the latch cycle. First `out_ready` 1 cycle after the ack for a non-final block, 2 cycles for a final block.
- `in_ready` held high across blocks: the next block is taken only after the last word of the current block transfers. Throughput is 1 word per cycle while unstalled, plus the IDLE/CHECK bubbles.
- `pad_error` remains set across later blocks until reset. Processing continues normally after an error.

Decomposition:
- Shared package `keccak_pkg`:
  - constants `PAD_FIRST`=8'h01, `PAD_LAST`=8'h80, `PAD_BOTH`=8'h81, `WORD_W`=32;
  - the unpadder state enum.
- Sub-module `unpad_locate`: purely combinational. Takes the block and returns `valid`, L (7 bits) and `rem`. It is instantiated in CHECK and is reusable by a future padder self-checker.

Test Plan:
- Final block {8'h01, 560'h0, 8'h80} -> 1 word: `out`=0, `is_last`=1, `byte_num`=0; one `in_ack`; `pad_error`=0.
- Final block {{8{64'h1234567890ABCDEF}}, 64'h1234567890ABCD81} -> 17 full words alternating 12345678/90ABCDEF, then `out`=32'h90ABCD00 with `is_last`=1, `byte_num`=3.
- Final block {{8{64'h1234567890ABCDEF}}, 64'h0100000000000080} -> 16 full words, then `out`=0 with `is_last`=1, `byte_num`=0.
- Two-block message:
  - Block 1 = {9{64'h1234567890ABCDEF}}, non-final -> 18 words, no `is_last`.
  - Hold `sink_full`=1 for 3 cycles mid-block -> `out` held, no word lost or duplicated.
  - Block 2 = {{8{64'h1234567890ABCDEF}}, 64'h1234567890AB0180}, final -> 17 full words, then 32'h90AB0000 with `is_last`=1, `byte_num`=2.
- Malformed final block {8'h02, 560'h0, 8'h80} -> `pad_error`=1, zero words emitted. A following valid empty block is still emitted correctly.
- Assert `reset` for 1 cycle at word 5 of an 18-word block -> all outputs 0 the next cycle. Then, with `in_ready`=0, no `out_ready` for 10 cycles.
